// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment readback decoder:
// segment patterns, pattern-to-hex lookup and the frame FSM state type.
package sevenseg_pkg;

   // Normal-polarity patterns {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } dec_state_t;

   // Returns {ok, nibble}; unknown patterns give ok=0 and nibble 0
   function automatic logic [4:0] seg2hex(input logic [6:0] seg);
      logic [4:0] res;
      case (seg)
         SEG_0:   res = {1'b1, 4'h0};
         SEG_1:   res = {1'b1, 4'h1};
         SEG_2:   res = {1'b1, 4'h2};
         SEG_3:   res = {1'b1, 4'h3};
         SEG_4:   res = {1'b1, 4'h4};
         SEG_5:   res = {1'b1, 4'h5};
         SEG_6:   res = {1'b1, 4'h6};
         SEG_7:   res = {1'b1, 4'h7};
         SEG_8:   res = {1'b1, 4'h8};
         SEG_9:   res = {1'b1, 4'h9};
         SEG_A:   res = {1'b1, 4'hA};
         SEG_B:   res = {1'b1, 4'hB};
         SEG_C:   res = {1'b1, 4'hC};
         SEG_D:   res = {1'b1, 4'hD};
         SEG_E:   res = {1'b1, 4'hE};
         SEG_F:   res = {1'b1, 4'hF};
         default: res = 5'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/sevenseg_stable.sv
// Input conditioning for the display bus: 2-flop synchroniser, polarity
// normalisation and a dwell counter that strobes once per stable value.
module sevenseg_stable #(
   parameter int DIGITS         = 4,
   parameter int STABLE_CYCLES  = 16,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        seg_i,
   input  logic [DIGITS-1:0] dig_en_i,
   output logic [6:0]        stable_seg,
   output logic [DIGITS-1:0] stable_dig_en,
   output logic              stable_event
);

   localparam int W  = 7 + DIGITS;
   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 2);

   logic [W-1:0]  sync1_reg;
   logic [W-1:0]  sync2_reg;
   logic [W-1:0]  prev_reg;
   logic [W-1:0]  sample;
   logic [CW-1:0] cnt_reg;
   logic          same;

   assign sample = (SEG_ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;
   assign same   = (sample == prev_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         prev_reg  <= '0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= {seg_i, dig_en_i};
         sync2_reg <= sync1_reg;
         prev_reg  <= sample;
         if (!same) begin
            cnt_reg <= '0;
         end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   // Fires in the cycle the counter steps onto its saturation value, so the
   // capturing edge lands exactly when the dwell completes; saturation blocks re-firing.
   assign stable_event = same && (cnt_reg == CNT_ARM);

   assign {stable_seg, stable_dig_en} = prev_reg;

endmodule

// File: rtl/sevenseg_decode.sv
// Seven-segment bus readback: decodes each multiplexed digit, assembles a
// full frame and hands it out over a valid/ready handshake.
module sevenseg_decode
   import sevenseg_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int STABLE_CYCLES  = 16,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          seg_i,
   input  logic [DIGITS-1:0]   dig_en_i,
   output logic [4*DIGITS-1:0] frame_o,
   output logic [DIGITS-1:0]   digit_ok_o,
   output logic                frame_valid_o,
   input  logic                frame_ready_i,
   output logic                err_o
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [6:0]          stab_seg;
   logic [DIGITS-1:0]   stab_en;
   logic                stab_event;
   logic [4:0]          dec;
   logic                en_none;
   logic                en_single;
   logic                capture;
   logic                multi_hot;
   logic [IW-1:0]       slot_idx;

   logic [DIGITS-1:0]   mask_reg;
   logic [DIGITS-1:0]   mask_next;
   logic [4*DIGITS-1:0] slot_nib_reg;
   logic [4*DIGITS-1:0] slot_nib_next;
   logic [DIGITS-1:0]   slot_ok_reg;
   logic [DIGITS-1:0]   slot_ok_next;
   dec_state_t          state_reg;
   logic [4*DIGITS-1:0] frame_reg;
   logic [DIGITS-1:0]   ok_reg;
   logic                valid_reg;
   logic                err_reg;

   sevenseg_stable #(
      .DIGITS         (DIGITS),
      .STABLE_CYCLES  (STABLE_CYCLES),
      .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
   ) u_stable (
      .clk           (clk),
      .rst           (rst),
      .seg_i         (seg_i),
      .dig_en_i      (dig_en_i),
      .stable_seg    (stab_seg),
      .stable_dig_en (stab_en),
      .stable_event  (stab_event)
   );

   assign dec       = seg2hex(stab_seg);
   assign en_none   = (stab_en == '0);
   assign en_single = ((stab_en & (stab_en - 1'b1)) == '0);
   assign capture   = stab_event && !en_none && en_single && (state_reg == COLLECT);
   assign multi_hot = stab_event && !en_none && !en_single;

   // OR of set-bit positions; only meaningful when the enable is one-hot
   always_comb begin
      slot_idx = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (stab_en[k]) begin
            slot_idx = slot_idx | IW'(k);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
         logic wr;
         assign wr                        = capture && (slot_idx == IW'(gi));
         assign slot_nib_next[4*gi +: 4]  = wr ? dec[3:0] : slot_nib_reg[4*gi +: 4];
         assign slot_ok_next[gi]          = wr ? dec[4]   : slot_ok_reg[gi];
         assign mask_next[gi]             = mask_reg[gi] | wr;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_reg     <= '0;
         slot_nib_reg <= '0;
         slot_ok_reg  <= '0;
         state_reg    <= COLLECT;
         frame_reg    <= '0;
         ok_reg       <= '0;
         valid_reg    <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         err_reg      <= multi_hot;
         slot_nib_reg <= slot_nib_next;
         slot_ok_reg  <= slot_ok_next;
         case (state_reg)
            COLLECT: begin
               mask_reg <= mask_next;
               if (&mask_next) begin
                  state_reg <= PRESENT;
                  valid_reg <= 1'b1;
                  frame_reg <= slot_nib_next;
                  ok_reg    <= slot_ok_next;
               end
            end
            PRESENT: begin
               if (frame_ready_i) begin
                  state_reg <= COLLECT;
                  mask_reg  <= '0;
                  valid_reg <= 1'b0;
               end
            end
            default: state_reg <= COLLECT;
         endcase
      end
   end

   assign frame_o       = frame_reg;
   assign digit_ok_o    = ok_reg;
   assign frame_valid_o = valid_reg;
   assign err_o         = err_reg;

endmodule

// File: tb/tb_sevenseg_decode.sv
// Directed and randomized checks of the seven-segment readback decoder
// against a hold-level behavioural model of the display bus.
module tb_sevenseg_decode;

   localparam int DIGITS = 4;
   localparam int S      = 16;

   logic        clk;
   logic        rst;
   logic [6:0]  seg_pin;
   logic [3:0]  en_pin;
   logic [15:0] frame;
   logic [3:0]  digit_ok;
   logic        valid;
   logic        frame_ready;
   logic        err;

   sevenseg_decode #(
      .DIGITS         (DIGITS),
      .STABLE_CYCLES  (S),
      .SEG_ACTIVE_LOW (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .seg_i         (seg_pin),
      .dig_en_i      (en_pin),
      .frame_o       (frame),
      .digit_ok_o    (digit_ok),
      .frame_valid_o (valid),
      .frame_ready_i (frame_ready),
      .err_o         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int errors   = 0;
   int checks   = 0;
   int err_seen = 0;
   int exp_err  = 0;

   // Model: slot contents, captured mask, presenting flag, current pins and dwell length
   int          m_nib  [4];
   bit          m_ok   [4];
   bit          m_mask [4];
   bit          m_present;
   logic [10:0] cur;
   int          run;

   always @(negedge clk) if (err === 1'b1) err_seen++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_lookup(input logic [6:0] p);
      for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
      return -1;
   endfunction

   function automatic logic [15:0] m_frame();
      logic [15:0] f;
      f = '0;
      for (int k = 0; k < 4; k++) f[4*k +: 4] = 4'(m_nib[k]);
      return f;
   endfunction

   function automatic logic [3:0] m_okv();
      logic [3:0] o;
      for (int k = 0; k < 4; k++) o[k] = m_ok[k];
      return o;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 4; k++) begin
         m_nib[k] = 0; m_ok[k] = 1'b0; m_mask[k] = 1'b0;
      end
      m_present = 1'b0;
   endtask

   // A value held for S clocks yields one event
   task automatic model_event();
      logic [3:0] en;
      int k;
      int h;
      en = cur[3:0];
      k  = 0;
      if ($countones(en) > 1) begin
         exp_err++;
      end else if ($countones(en) == 1 && !m_present) begin
         for (int i = 0; i < 4; i++) if (en[i]) k = i;
         h = ref_lookup(cur[10:4]);
         m_nib[k]  = (h < 0) ? 0 : h;
         m_ok[k]   = (h >= 0);
         m_mask[k] = 1'b1;
         if (m_mask[0] && m_mask[1] && m_mask[2] && m_mask[3]) m_present = 1'b1;
      end
   endtask

   task automatic set_pins(input logic [6:0] pat, input logic [3:0] en);
      if ({pat, en} !== cur) begin
         cur = {pat, en};
         run = 0;
      end
      seg_pin = ~pat;
      en_pin  = ~en;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         run++;
         if (run == S) model_event();
      end
      #1;
   endtask

   task automatic hold(input logic [6:0] pat, input logic [3:0] en, input int n);
      set_pins(pat, en);
      step(n);
      $display("hold pat=%02h en=%b len=%0d valid=%0b frame=%04h ok=%h", pat, en, n, valid, frame, digit_ok);
   endtask

   task automatic check_model(input string tag);
      check({tag, "_valid"}, 32'(valid), 32'(m_present));
      if (m_present) begin
         check({tag, "_frame"}, 32'(frame), 32'(m_frame()));
         check({tag, "_ok"}, 32'(digit_ok), 32'(m_okv()));
      end
   endtask

   task automatic accept(input string tag);
      frame_ready = 1'b1;
      step(1);
      frame_ready = 1'b0;
      m_present = 1'b0;
      for (int k = 0; k < 4; k++) m_mask[k] = 1'b0;
      check({tag, "_drop"}, 32'(valid), 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      frame_ready = 1'b0;
      set_pins(7'h00, 4'h0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      run = 0;
   endtask

   initial begin
      int e0;
      logic [6:0] p;
      logic [3:0] e;
      int r;
      int len;
      bit done;

      rst = 1'b1;
      frame_ready = 1'b0;
      cur = '0;
      run = 0;
      seg_pin = 7'h7F;
      en_pin = 4'hF;
      model_clear();
      #3;
      check("rst_frame", 32'(frame), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_ok", 32'(digit_ok), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      do_reset();
      step(2);
      check("post_rst_valid", 32'(valid), 32'h0);

      // 1: basic frame
      hold(7'h3F, 4'b0001, 20);
      hold(7'h4F, 4'b0010, 20);
      hold(7'h7C, 4'b0100, 20);
      hold(7'h71, 4'b1000, 20);
      check("t1_frame", 32'(frame), 32'hFB30);
      check("t1_ok", 32'(digit_ok), 32'hF);
      check("t1_valid", 32'(valid), 32'h1);
      check_model("t1");

      // 2: back-pressure, pins ignored while presenting
      hold(7'h06, 4'b0001, 25);
      hold(7'h5B, 4'b0010, 25);
      check("t2_frame", 32'(frame), 32'hFB30);
      check("t2_valid", 32'(valid), 32'h1);
      check("t2_ok", 32'(digit_ok), 32'hF);
      accept("t2");

      // 3: short glitch on digit 2
      hold(7'h06, 4'b0001, 20);
      hold(7'h5B, 4'b0010, 20);
      hold(7'h5B, 4'b0100, 10);
      hold(7'h06, 4'b0100, 20);
      hold(7'h66, 4'b1000, 20);
      check("t3_frame", 32'(frame), 32'h4121);
      check("t3_ok", 32'(digit_ok), 32'hF);
      check_model("t3");
      accept("t3");

      // 4: illegal pattern on digit 1
      hold(7'h6D, 4'b0001, 20);
      hold(7'h41, 4'b0010, 20);
      hold(7'h7D, 4'b0100, 20);
      hold(7'h07, 4'b1000, 20);
      check("t4_frame", 32'(frame), 32'h7605);
      check("t4_ok", 32'(digit_ok), 32'hD);
      check_model("t4");
      accept("t4");

      // 5: multi-hot error pulse timing, blanking, dwell boundary
      hold(7'h00, 4'b0000, 20);
      e0 = err_seen;
      set_pins(7'h3F, 4'b0110);
      step(S + 1);
      check("t5_err_early", 32'(err), 32'h0);
      step(1);
      check("t5_err_pulse", 32'(err), 32'h1);
      step(1);
      check("t5_err_after", 32'(err), 32'h0);
      step(2);
      check("t5_err_count", 32'(err_seen - e0), 32'h1);
      e0 = err_seen;
      hold(7'h3F, 4'b0000, 20);
      check("t5_blank_err", 32'(err_seen - e0), 32'h0);
      hold(7'h3F, 4'b0001, 20);
      hold(7'h3F, 4'b1000, 20);
      check("t5_no_slot", 32'(valid), 32'h0);
      hold(7'h06, 4'b0010, 20);
      hold(7'h5B, 4'b0100, 20);
      check("t5_frame", 32'(frame), 32'h0210);
      check_model("t5");
      accept("t5");
      hold(7'h00, 4'b0000, 20);
      e0 = err_seen;
      hold(7'h6D, 4'b0101, S - 1);
      hold(7'h00, 4'b0000, 20);
      check("t5_dwell_short", 32'(err_seen - e0), 32'h0);
      hold(7'h6D, 4'b0101, S);
      hold(7'h00, 4'b0000, 20);
      check("t5_dwell_exact", 32'(err_seen - e0), 32'h1);

      // 6: asynchronous reset while presenting, then partial frame discarded
      hold(7'h7D, 4'b0001, 20);
      hold(7'h07, 4'b0010, 20);
      hold(7'h7F, 4'b0100, 20);
      hold(7'h6F, 4'b1000, 20);
      check("t6_frame", 32'(frame), 32'h9876);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("t6_async_valid", 32'(valid), 32'h0);
      check("t6_async_frame", 32'(frame), 32'h0);
      check("t6_async_ok", 32'(digit_ok), 32'h0);
      do_reset();
      hold(7'h3F, 4'b0001, 20);
      hold(7'h06, 4'b0010, 20);
      hold(7'h5B, 4'b0100, 20);
      do_reset();
      hold(7'h4F, 4'b1000, 20);
      check("t6_partial", 32'(valid), 32'h0);
      check_model("t6a");
      hold(7'h66, 4'b0001, 20);
      hold(7'h6D, 4'b0010, 20);
      hold(7'h7D, 4'b0100, 20);
      check("t6_frame2", 32'(frame), 32'h3654);
      check_model("t6b");
      accept("t6");

      // Randomized holds against the model
      for (int f = 0; f < 6; f++) begin
         done = 1'b0;
         for (int h = 0; h < 60 && !done; h++) begin
            do begin
               p = ($urandom_range(0, 9) < 8) ? tbl[$urandom_range(0, 15)] : 7'($urandom);
               r = $urandom_range(0, 9);
               if (r < 8) e = 4'(1 << $urandom_range(0, 3));
               else if (r == 8) e = 4'h0;
               else begin
                  do e = 4'($urandom); while ($countones(e) < 2);
               end
            end while ({p, e} === cur);
            len = ($urandom_range(0, 9) < 3) ? $urandom_range(2, S - 1) : $urandom_range(S + 4, S + 10);
            hold(p, e, len);
            check_model("rnd");
            if (m_present) begin
               accept("rnd");
               done = 1'b1;
            end
         end
      end
      step(4);
      check("err_total", 32'(err_seen), 32'(exp_err));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
